led_bank_arbiter: RTL

//  Shares one bank of LEDs between NUM_REQ requesters; sits between user logic and LED pins.
//  A built-in prescaler generates a tick every 2**LOG2DELAY clocks. With no owner, the bank shows
//  the Gray-coded idle counter. Requesters win the bank round-robin, display a latched pattern
//  for a requested number of ticks, then release it.

---
 rtl/led_pkg.sv | 17 +
 rtl/led_tick_prescaler.sv | 24 ++
 rtl/led_bank_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types, defaults and Gray helper for the LED bank arbiter
package led_pkg;

  localparam int LEDS_DEFAULT      = 5;
  localparam int LOG2DELAY_DEFAULT = 21;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic logic [31:0] gray32(input logic [31:0] x);
    return x ^ (x >> 1);
  endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// rtl/led_tick_prescaler.sv - free-running prescaler, one-cycle tick when the counter is all-ones
module led_tick_prescaler
  import led_pkg::*;
#(
  parameter int LOG2DELAY = LOG2DELAY_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [LOG2DELAY-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + LOG2DELAY'(1);
    end
  end

  assign tick = &cnt;

endmodule

// File: rtl/led_bank_arbiter.sv
// rtl/led_bank_arbiter.sv - round-robin owner of one LED bank; shows Gray idle count when unowned
module led_bank_arbiter
  import led_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int LEDS      = LEDS_DEFAULT,
  parameter int LOG2DELAY = LOG2DELAY_DEFAULT,
  parameter int HOLD_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LEDS-1:0]    req_pattern,
  input  logic [NUM_REQ*HOLD_W-1:0]  req_hold,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [LEDS-1:0]            led
);

  localparam int IW = $clog2(NUM_REQ);

  state_t              state, state_next;
  logic                tick;
  logic [IW-1:0]       owner, rr_ptr, win;
  logic [HOLD_W-1:0]   remaining, win_hold;
  logic [LEDS-1:0]     idle_cnt, pattern, win_pattern, idle_gray;
  logic [IW:0]         pick;
  logic                completed, grant, owner_req, abort, finish;

  // Returns {found, index}: first set request scanning ptr, ptr+1, ... modulo NUM_REQ.
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [IW-1:0] ptr);
    logic [IW:0]        res;
    logic [NUM_REQ-1:0] shifted;
    int                 idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx     = (int'(ptr) + k) % NUM_REQ;
      shifted = r >> idx;
      if (shifted[0]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  led_tick_prescaler #(.LOG2DELAY(LOG2DELAY)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    pick        = rr_pick(req, rr_ptr);
    win         = pick[IW-1:0];
    owner_req   = |(req & (NUM_REQ'(1) << owner));
    grant       = (state == IDLE) && pick[IW];
    abort       = (state == SHOW) && !owner_req;
    finish      = (state == SHOW) && owner_req && tick && (remaining == HOLD_W'(1));
    win_pattern = LEDS'(req_pattern >> (int'(win) * LEDS));
    win_hold    = HOLD_W'(req_hold >> (int'(win) * HOLD_W));
    idle_gray   = LEDS'(gray32(32'(idle_cnt)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = SHOW;
      SHOW:    if (abort || finish) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // gnt/busy/done decode straight from registers so an async reset clears them at once.
  always_comb begin
    gnt  = '0;
    done = '0;
    busy = 1'b0;
    case (state)
      SHOW: begin
        gnt  = NUM_REQ'(1) << owner;
        busy = 1'b1;
      end
      RELEASE: if (completed) done = NUM_REQ'(1) << owner;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= '0;
      rr_ptr    <= '0;
      remaining <= '0;
      completed <= 1'b0;
      idle_cnt  <= '0;
      pattern   <= '0;
      led       <= '0;
    end else begin
      if (state == IDLE && tick) idle_cnt <= idle_cnt + LEDS'(1);
      case (state)
        IDLE: begin
          if (grant) begin
            owner     <= win;
            rr_ptr    <= (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
            pattern   <= win_pattern;
            remaining <= (win_hold == '0) ? HOLD_W'(1) : win_hold;
            completed <= 1'b0;
            led       <= win_pattern;
          end else begin
            led <= idle_gray;
          end
        end
        SHOW: begin
          led       <= pattern;
          completed <= finish;
          if (!abort && tick) remaining <= remaining - HOLD_W'(1);
        end
        default: led <= idle_gray;
      endcase
    end
  end

endmodule
